// File: rtl/camera_eth_pkt_ctrl.sv
// Packetises buffered camera lines from a byte FIFO into a UDP transmitter.
// Optional packet counter output Pkt_cnt enabled by `define CAMERA_ETH_PKT_STAT_EN.
module camera_eth_pkt_ctrl #(
  parameter logic [15:0] LINE_BYTES = 16'd1282,
  parameter logic [15:0] IFG_CYCLES = 16'd100
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        fifo_clr,
  input  logic [11:0] fifo_rdusedw,
  input  logic [7:0]  fifo_rddata,
  output logic        fifo_rdreq,
  output logic        Tx_En_Pulse,
  output logic [15:0] Lenth,
  input  logic        Payload_req,
  output logic [7:0]  Payload_dat,
  input  logic        Tx_Done,
  output logic        Busy
`ifdef CAMERA_ETH_PKT_STAT_EN
  ,
  output logic [31:0] Pkt_cnt
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_LINE = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] GAP       = 3'd5;

  localparam logic [11:0] LINE_LEN  = LINE_BYTES[11:0];
  localparam logic [11:0] LINE_LAST = LINE_LEN - 12'd1;
  localparam logic [15:0] GAP_LAST  = IFG_CYCLES - 16'd1;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [11:0] byte_cnt;
  logic [15:0] gap_cnt;
  logic        rd_q;

  // Next state and the combinational FIFO read strobe; a clear overrides everything.
  always_comb begin
    state_nxt  = state;
    fifo_rdreq = 1'b0;
    case (state)
      IDLE:      if (!fifo_clr) state_nxt = WAIT_LINE;
      WAIT_LINE: if (fifo_rdusedw >= LINE_LEN) state_nxt = START;
      START:     state_nxt = SEND;
      SEND: begin
        fifo_rdreq = Payload_req && (byte_cnt < LINE_LEN);
        if (Tx_Done || (fifo_rdreq && (byte_cnt == LINE_LAST))) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (Tx_Done) state_nxt = GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_nxt = WAIT_LINE;
      default:   state_nxt = IDLE;
    endcase
    if (fifo_clr) begin
      state_nxt  = IDLE;
      fifo_rdreq = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      byte_cnt    <= 12'd0;
      gap_cnt     <= 16'd0;
      rd_q        <= 1'b0;
      Tx_En_Pulse <= 1'b0;
      Busy        <= 1'b0;
      Lenth       <= LINE_BYTES;
    end else begin
      state       <= state_nxt;
      rd_q        <= fifo_rdreq;
      Tx_En_Pulse <= (state_nxt == START);
      Busy        <= !((state_nxt == IDLE) || (state_nxt == WAIT_LINE));
      Lenth       <= LINE_BYTES;

      if (fifo_clr || ((state == WAIT_DONE) && Tx_Done)) byte_cnt <= 12'd0;
      else if (fifo_rdreq)                               byte_cnt <= byte_cnt + 12'd1;

      // Zero outside GAP so the count always starts fresh on entry.
      if (fifo_clr || (state != GAP)) gap_cnt <= 16'd0;
      else                            gap_cnt <= gap_cnt + 16'd1;
    end
  end

  // FIFO data arrives one cycle after the read; suppressed requests yield zero.
  assign Payload_dat = rd_q ? fifo_rddata : 8'h00;

`ifdef CAMERA_ETH_PKT_STAT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                              Pkt_cnt <= 32'd0;
    else if (fifo_clr)                       Pkt_cnt <= 32'd0;
    else if ((state == WAIT_DONE) && Tx_Done) Pkt_cnt <= Pkt_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_camera_eth_pkt_ctrl.sv
// Randomised bench for camera_eth_pkt_ctrl with a queue-based FIFO and transmitter model.
// Define CAMERA_ETH_PKT_STAT_EN to also check Pkt_cnt.
module tb_camera_eth_pkt_ctrl;

  localparam int unsigned LB  = 1282;
  localparam int unsigned IFG = 100;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        fifo_clr;
  logic [11:0] fifo_rdusedw;
  logic [7:0]  fifo_rddata;
  logic        fifo_rdreq;
  logic        Tx_En_Pulse;
  logic [15:0] Lenth;
  logic        Payload_req;
  logic [7:0]  Payload_dat;
  logic        Tx_Done;
  logic        Busy;
`ifdef CAMERA_ETH_PKT_STAT_EN
  logic [31:0] Pkt_cnt;
`endif

  camera_eth_pkt_ctrl #(.LINE_BYTES(16'(LB)), .IFG_CYCLES(16'(IFG))) dut (
    .Clk(Clk), .Rst_n(Rst_n), .fifo_clr(fifo_clr), .fifo_rdusedw(fifo_rdusedw),
    .fifo_rddata(fifo_rddata), .fifo_rdreq(fifo_rdreq), .Tx_En_Pulse(Tx_En_Pulse),
    .Lenth(Lenth), .Payload_req(Payload_req), .Payload_dat(Payload_dat),
    .Tx_Done(Tx_Done), .Busy(Busy)
`ifdef CAMERA_ETH_PKT_STAT_EN
    , .Pkt_cnt(Pkt_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  logic [7:0] fifo_q[$];
  logic [7:0] line_exp[$];
  logic [7:0] rx_q[$];
  logic       rd_seen, last_pulse, req_prev;
  int         rd_cnt, pulse_cnt, pkt_model, n_tests, n_fail;
  logic [7:0] seq_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_level();
    fifo_rdusedw = (fifo_q.size() > 4095) ? 12'd4095 : 12'(fifo_q.size());
  endtask

  // One clock: observe at negedge, then model the FIFO read just after the edge.
  task automatic tick();
    @(negedge Clk);
    rd_seen    = fifo_rdreq;
    last_pulse = Tx_En_Pulse;
    if (Tx_En_Pulse) pulse_cnt++;
    if (rd_seen) begin
      rd_cnt++;
      check("no_underflow", 32'(fifo_q.size() != 0), 32'd1);
    end
    if (req_prev) rx_q.push_back(Payload_dat);
    req_prev = Payload_req;
    @(posedge Clk);
    #1;
    if (rd_seen && fifo_q.size() != 0) fifo_rddata = fifo_q.pop_front();
    else                               fifo_rddata = 8'($urandom);
    set_level();
  endtask

  task automatic push_bytes(input int n, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (rnd) b = 8'($urandom);
      else begin
        b = seq_byte;
        seq_byte = seq_byte + 8'd1;
      end
      fifo_q.push_back(b);
      line_exp.push_back(b);
    end
    set_level();
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n;
    n = 0;
    last_pulse = 1'b0;
    while (!last_pulse && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(last_pulse), 32'd1);
    check({tag, "_lenth"}, 32'(Lenth), 32'(LB));
    tick();
    check({tag, "_width"}, 32'(last_pulse), 32'd0);
  endtask

  // Transmitter: issues requests, collects bytes, checks them against the buffered line.
  task automatic send_pkt(input int extra, input int pct);
    int reqs, cyc;
    logic [7:0] e;
    reqs = 0;
    cyc = 0;
    rx_q.delete();
    rd_cnt = 0;
    while (reqs < int'(LB) + extra && cyc < 20000) begin
      Payload_req = ($urandom_range(99) < pct);
      if (Payload_req) reqs++;
      tick();
      cyc++;
    end
    Payload_req = 1'b0;
    tick();
    check("pkt_rdreq_cnt", 32'(rd_cnt), 32'(LB));
    check("pkt_rx_len", 32'(rx_q.size()), 32'(reqs));
    for (int i = 0; i < rx_q.size(); i++) begin
      e = 8'h00;
      if (i < int'(LB) && line_exp.size() != 0) e = line_exp.pop_front();
      check("pkt_byte", 32'(rx_q[i]), 32'(e));
    end
    check("wait_done_busy", 32'(Busy), 32'd1);
  endtask

  task automatic tx_done();
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0;
    n_tests = 0; n_fail = 0; rd_cnt = 0; pulse_cnt = 0; pkt_model = 0;
    seq_byte = 8'h00; req_prev = 1'b0; rd_seen = 1'b0; last_pulse = 1'b0;
    Rst_n = 1'b0; fifo_clr = 1'b1; fifo_rdusedw = 12'd0; fifo_rddata = 8'h00;
    Payload_req = 1'b0; Tx_Done = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    check("rst_pulse", 32'(Tx_En_Pulse), 32'd0);
    check("rst_dat", 32'(Payload_dat), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_lenth", 32'(Lenth), 32'(LB));
    Rst_n = 1'b1;
    tick();
    tick();

    // One byte short of a line: must stay waiting.
    push_bytes(int'(LB) - 1, 1'b0);
    fifo_clr = 1'b0;
    p0 = pulse_cnt;
    repeat (20) tick();
    check("short_line_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("short_line_busy", 32'(Busy), 32'd0);
    push_bytes(1, 1'b0);
    wait_pulse("full_line_pulse", 4);

    // Requests held for LB+8 cycles on a 0x00..0xFF pattern.
    send_pkt(8, 100);
    push_bytes(int'(LB), 1'b1);
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    pkt_model++;
    n = 0;
    last_pulse = 1'b0;
    while (!last_pulse && n < int'(IFG) + 20) begin
      tick();
      n++;
    end
    check("ifg_pulse_delay", 32'(n), 32'(IFG + 2));
`ifdef CAMERA_ETH_PKT_STAT_EN
    check("pkt_cnt_1", Pkt_cnt, 32'(pkt_model));
`endif
    tick();

    // Sparse random requests.
    send_pkt($urandom_range(0, 10), 60);
    push_bytes(int'(LB), 1'b1);
    tx_done();
    pkt_model++;
    wait_pulse("pkt3_pulse", int'(IFG) + 20);

    // Abort mid-line with a FIFO clear.
    rd_cnt = 0;
    Payload_req = 1'b1;
    repeat (500) tick();
    check("abort_rd_cnt", 32'(rd_cnt), 32'd500);
    fifo_clr = 1'b1;
    fifo_q.delete();
    line_exp.delete();
    set_level();
    tick();
    check("clr_rdreq_same_cycle", 32'(rd_seen), 32'd0);
    Payload_req = 1'b0;
    tick();
    check("clr_busy", 32'(Busy), 32'd0);
    pkt_model = 0;
    p0 = pulse_cnt;
    tx_done();
    repeat (3) tick();
    check("clr_txdone_busy", 32'(Busy), 32'd0);
    fifo_clr = 1'b0;
    tick();
    tx_done();
    repeat (5) tick();
    check("txdone_ignored_busy", 32'(Busy), 32'd0);
    check("txdone_ignored_pulse", 32'(pulse_cnt - p0), 32'd0);
`ifdef CAMERA_ETH_PKT_STAT_EN
    check("pkt_cnt_clr", Pkt_cnt, 32'(pkt_model));
`endif

    // Three complete packets after the clear.
    for (int k = 0; k < 3; k++) begin
      push_bytes(int'(LB), 1'b1);
      wait_pulse("post_clr_pulse", int'(IFG) + 20);
      send_pkt($urandom_range(0, 6), $urandom_range(40, 100));
      tx_done();
      pkt_model++;
`ifdef CAMERA_ETH_PKT_STAT_EN
      check("pkt_cnt_run", Pkt_cnt, 32'(pkt_model));
`endif
    end

    // Asynchronous reset in the middle of a line.
    push_bytes(int'(LB), 1'b1);
    wait_pulse("pre_reset_pulse", int'(IFG) + 20);
    Payload_req = 1'b1;
    repeat (300) tick();
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_rst_rdreq", 32'(fifo_rdreq), 32'd0);
    check("async_rst_pulse", 32'(Tx_En_Pulse), 32'd0);
    check("async_rst_dat", 32'(Payload_dat), 32'd0);
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_lenth", 32'(Lenth), 32'(LB));
`ifdef CAMERA_ETH_PKT_STAT_EN
    check("async_rst_pkt_cnt", Pkt_cnt, 32'd0);
`endif
    Payload_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
